// File: rtl/framebuffer_stream_pkg.sv
// Shared constants and payload types for the frame buffer stream FIFO.
// CSR address map, control-register bit positions and the per-word framing tag
// that travels with every data word through storage.
package framebuffer_stream_pkg;

    localparam int unsigned CSR_ADDR_WIDTH = 2;

    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_DATA  = 2'd0;
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_CTRL  = 2'd1;
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_LEVEL = 2'd2;
    localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_AFTHR = 2'd3;

    localparam int unsigned CTRL_SOP = 0;
    localparam int unsigned CTRL_EOP = 1;

    // Framing tag; a stored entry is {tag.sop, tag.eop, data}.
    typedef struct packed {
        logic sop;
        logic eop;
    } entry_tag_t;

endpackage

// File: rtl/framebuffer_stream_fifo_if.sv
// Bus bundle for the FIFO: Avalon-MM write/CSR slave plus Avalon-ST source.
// slave  : the FIFO's view (accepts MM accesses, drives the stream).
// master : the view of whoever drives MM accesses and sinks the stream.
interface framebuffer_stream_fifo_if
    import framebuffer_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [CSR_ADDR_WIDTH-1:0] avalonmm_slave_address;
    logic                      avalonmm_slave_write;
    logic [DATA_WIDTH-1:0]     avalonmm_slave_writedata;
    logic                      avalonmm_slave_read;
    logic [DATA_WIDTH-1:0]     avalonmm_slave_readdata;
    logic                      avalonmm_slave_waitrequest;

    logic [DATA_WIDTH-1:0]     avalonst_source_data;
    logic                      avalonst_source_valid;
    logic                      avalonst_source_ready;
    logic                      avalonst_source_startofpacket;
    logic                      avalonst_source_endofpacket;

    modport slave (
        input  avalonmm_slave_address, avalonmm_slave_write, avalonmm_slave_writedata,
        input  avalonmm_slave_read,
        output avalonmm_slave_readdata, avalonmm_slave_waitrequest,
        output avalonst_source_data, avalonst_source_valid,
        output avalonst_source_startofpacket, avalonst_source_endofpacket,
        input  avalonst_source_ready
    );

    modport master (
        output avalonmm_slave_address, avalonmm_slave_write, avalonmm_slave_writedata,
        output avalonmm_slave_read,
        input  avalonmm_slave_readdata, avalonmm_slave_waitrequest,
        input  avalonst_source_data, avalonst_source_valid,
        input  avalonst_source_startofpacket, avalonst_source_endofpacket,
        output avalonst_source_ready
    );
endinterface

// File: rtl/framebuffer_stream_fifo_ram.sv
// Simple dual-port storage for the FIFO: one write port, one read port with a
// registered read output that holds its value while rd_en is low.
// Ports: clock; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request;
// rd_data read result, valid the cycle after rd_en.
module framebuffer_stream_fifo_ram #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 8192,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Memory array carries no reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/framebuffer_stream_fifo.sv
// Avalon-MM write to Avalon-ST source FIFO bridge for the frame buffer.
// Data writes (address 0) are tagged with the pending sop/eop flags and stored;
// the head word is presented show-ahead on the stream with ready latency 0.
// Ports: clock, reset_n (async, active low); bus (slave modport: MM CSR/data
// slave and ST source); almost_full (level >= threshold); level (words held).
// Pipeline: RAM -> RAM read register -> head register; a word written into an
// empty FIFO is visible on the stream two edges later.
module framebuffer_stream_fifo
    import framebuffer_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 8192,
    parameter int unsigned LEVEL_WIDTH = $clog2(DEPTH) + 1,
    parameter int unsigned AF_DEFAULT  = DEPTH - 3
) (
    input  logic                    clock,
    input  logic                    reset_n,
    framebuffer_stream_fifo_if.slave bus,
    output logic                    almost_full,
    output logic [LEVEL_WIDTH-1:0]  level
);
    localparam int unsigned ADDR_WIDTH  = $clog2(DEPTH);
    localparam int unsigned ENTRY_WIDTH = DATA_WIDTH + 2;

    typedef struct packed {
        entry_tag_t            tag;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [ADDR_WIDTH-1:0]  rd_ptr;
    logic                   ram_out_valid;
    logic                   head_valid;
    entry_t                 head;
    entry_t                 ram_rd_data;
    entry_t                 ram_wr_data;
    logic                   pending_sop;
    logic                   pending_eop;
    logic [LEVEL_WIDTH-1:0] af_threshold;
    logic [DATA_WIDTH-1:0]  readdata;

    logic                   data_wr;
    logic                   ctrl_wr;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   head_load;
    logic                   ram_rd;
    logic [LEVEL_WIDTH-1:0] ram_count;
    logic [LEVEL_WIDTH-1:0] level_next;
    logic [LEVEL_WIDTH-1:0] threshold_next;
    logic [1:0]             ctrl_status;
    logic [DATA_WIDTH-1:0]  readdata_next;

    // Handshake, pipeline advance and next-value decode.
    always_comb begin
        data_wr   = bus.avalonmm_slave_write && (bus.avalonmm_slave_address == ADDR_DATA);
        ctrl_wr   = bus.avalonmm_slave_write && (bus.avalonmm_slave_address == ADDR_CTRL);
        full      = (level == LEVEL_WIDTH'(DEPTH));
        push      = data_wr && !full;
        pop       = head_valid && bus.avalonst_source_ready;
        head_load = ram_out_valid && (!head_valid || pop);
        // Words still sitting in the array, i.e. not yet fetched into a stage.
        ram_count = level - LEVEL_WIDTH'(head_valid) - LEVEL_WIDTH'(ram_out_valid);
        ram_rd    = (ram_count != '0) && (!ram_out_valid || head_load);
        level_next = level + LEVEL_WIDTH'(push) - LEVEL_WIDTH'(pop);

        threshold_next = af_threshold;
        if (bus.avalonmm_slave_write && (bus.avalonmm_slave_address == ADDR_AFTHR)) begin
            threshold_next = LEVEL_WIDTH'(bus.avalonmm_slave_writedata);
        end

        ram_wr_data.tag.sop = pending_sop;
        ram_wr_data.tag.eop = pending_eop;
        ram_wr_data.data    = bus.avalonmm_slave_writedata;

        ctrl_status           = '0;
        ctrl_status[CTRL_SOP] = pending_sop;
        ctrl_status[CTRL_EOP] = pending_eop;

        case (bus.avalonmm_slave_address)
            ADDR_CTRL:  readdata_next = DATA_WIDTH'(ctrl_status);
            ADDR_LEVEL: readdata_next = DATA_WIDTH'(level);
            ADDR_AFTHR: readdata_next = DATA_WIDTH'(af_threshold);
            default:    readdata_next = '0;
        endcase
    end

    framebuffer_stream_fifo_ram #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (ram_wr_data),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    // Pointers, occupancy and the two output stages.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            almost_full   <= 1'b0;
            ram_out_valid <= 1'b0;
            head_valid    <= 1'b0;
            head          <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            if (head_load) begin
                head <= ram_rd_data;
            end
            ram_out_valid <= ram_rd || (ram_out_valid && !head_load);
            head_valid    <= head_load || (head_valid && !pop);
            level         <= level_next;
            // Compared against the next threshold too, so the flag always equals level >= threshold.
            almost_full   <= (level_next >= threshold_next);
        end
    end

    // CSR state: framing flags, threshold and registered read data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pending_sop  <= 1'b0;
            pending_eop  <= 1'b0;
            af_threshold <= LEVEL_WIDTH'(AF_DEFAULT);
            readdata     <= '0;
        end else begin
            // A stalled data write leaves the flags pending for the retry.
            if (push) begin
                pending_sop <= 1'b0;
                pending_eop <= 1'b0;
            end else if (ctrl_wr) begin
                if (bus.avalonmm_slave_writedata[CTRL_SOP]) begin
                    pending_sop <= 1'b1;
                end
                if (bus.avalonmm_slave_writedata[CTRL_EOP]) begin
                    pending_eop <= 1'b1;
                end
            end
            af_threshold <= threshold_next;
            if (bus.avalonmm_slave_read) begin
                readdata <= readdata_next;
            end
        end
    end

    assign bus.avalonmm_slave_readdata       = readdata;
    assign bus.avalonmm_slave_waitrequest    = data_wr && full;
    assign bus.avalonst_source_data          = head.data;
    assign bus.avalonst_source_valid         = head_valid;
    assign bus.avalonst_source_startofpacket = head.tag.sop;
    assign bus.avalonst_source_endofpacket   = head.tag.eop;

endmodule

// File: tb/tb_framebuffer_stream_fifo.sv
// Self-checking bench for framebuffer_stream_fifo (DEPTH=8, DATA_WIDTH=32).
// Reference model: a queue of words, each stamped with the edge from which it
// may be shown (accept edge + 2); level is the queue size.
module tb_framebuffer_stream_fifo;
    import framebuffer_stream_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LW    = 4;
    localparam int unsigned AFD   = DEPTH - 3;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          almost_full;
    logic [LW-1:0] level;

    framebuffer_stream_fifo_if #(.DATA_WIDTH(DW)) bus ();

    framebuffer_stream_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .bus         (bus),
        .almost_full (almost_full),
        .level       (level)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        int            rc;
    } mword_t;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic        rdy;
        int          exp_level;
        logic        exp_af;
        logic        exp_valid;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    mword_t q[$];
    mword_t seen[$];
    int     cyc;
    logic   m_psop;
    logic   m_peop;
    int     m_thr;
    int     errors;
    int     checks;
    logic   wreq_seen;
    vec_t   vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic m_valid();
        return (q.size() > 0) && (q[0].rc <= cyc);
    endfunction

    task automatic drive(input logic wr, input logic rd, input logic [1:0] addr,
                         input logic [31:0] wd, input logic rdy);
        bus.avalonmm_slave_write     = wr;
        bus.avalonmm_slave_read      = rd;
        bus.avalonmm_slave_address   = addr;
        bus.avalonmm_slave_writedata = wd;
        bus.avalonst_source_ready    = rdy;
    endtask

    task automatic model_reset();
        q.delete();
        m_psop = 1'b0;
        m_peop = 1'b0;
        m_thr  = int'(AFD);
        cyc    = 0;
    endtask

    // One clock: inputs already driven at the falling edge; checks after it.
    task automatic cycle();
        logic          wreq, push, pop, rd_chk, wr;
        logic [1:0]    a;
        logic [DW-1:0] wd, exp_rd;
        mword_t        w;
        #1;
        wr   = bus.avalonmm_slave_write;
        a    = bus.avalonmm_slave_address;
        wd   = bus.avalonmm_slave_writedata;
        wreq = wr && (a == ADDR_DATA) && (q.size() == int'(DEPTH));
        wreq_seen = bus.avalonmm_slave_waitrequest;
        check("waitrequest", 64'(bus.avalonmm_slave_waitrequest), 64'(wreq));
        push = wr && (a == ADDR_DATA) && !wreq;
        pop  = m_valid() && bus.avalonst_source_ready;
        if (bus.avalonst_source_valid && bus.avalonst_source_ready) begin
            w.data = bus.avalonst_source_data;
            w.sop  = bus.avalonst_source_startofpacket;
            w.eop  = bus.avalonst_source_endofpacket;
            w.rc   = cyc;
            seen.push_back(w);
        end
        rd_chk = bus.avalonmm_slave_read && (a != ADDR_DATA);
        case (a)
            ADDR_CTRL:  exp_rd = DW'({m_peop, m_psop});
            ADDR_LEVEL: exp_rd = DW'(q.size());
            default:    exp_rd = DW'(m_thr);
        endcase
        @(posedge clock);
        cyc++;
        if (pop) q.delete(0);
        if (push) begin
            w.data = wd;
            w.sop  = m_psop;
            w.eop  = m_peop;
            w.rc   = cyc + 2;
            q.push_back(w);
            m_psop = 1'b0;
            m_peop = 1'b0;
        end else if (wr && (a == ADDR_CTRL)) begin
            if (wd[0]) m_psop = 1'b1;
            if (wd[1]) m_peop = 1'b1;
        end
        if (wr && (a == ADDR_AFTHR)) m_thr = int'(wd[LW-1:0]);
        @(negedge clock);
        check("valid", 64'(bus.avalonst_source_valid), 64'(m_valid()));
        if (m_valid()) begin
            check("data", 64'(bus.avalonst_source_data), 64'(q[0].data));
            check("sop", 64'(bus.avalonst_source_startofpacket), 64'(q[0].sop));
            check("eop", 64'(bus.avalonst_source_endofpacket), 64'(q[0].eop));
        end
        check("level", 64'(level), 64'(q.size()));
        check("almost_full", 64'(almost_full), 64'(q.size() >= m_thr));
        if (rd_chk) check("readdata", 64'(bus.avalonmm_slave_readdata), 64'(exp_rd));
    endtask

    task automatic idle(input logic rdy, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, ADDR_DATA, 32'h0, rdy);
            cycle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int bubbles, max_lvl;
        logic started;
        errors = 0;
        checks = 0;
        model_reset();
        drive(1'b0, 1'b0, ADDR_DATA, 32'h0, 1'b0);

        // Reset state
        @(negedge clock);
        check("rst valid", 64'(bus.avalonst_source_valid), 64'(0));
        check("rst data", 64'(bus.avalonst_source_data), 64'(0));
        check("rst sop/eop", 64'({bus.avalonst_source_startofpacket, bus.avalonst_source_endofpacket}), 64'(0));
        check("rst level", 64'(level), 64'(0));
        check("rst almost_full", 64'(almost_full), 64'(0));
        check("rst readdata", 64'(bus.avalonmm_slave_readdata), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;

        // Single word: accepted at edge 1, visible from edge 3, popped at edge 4
        drive(1'b1, 1'b0, ADDR_DATA, 32'hA5A5_A5A5, 1'b1);
        cycle();
        check("t1 e1 level", 64'(level), 64'(1));
        check("t1 e1 valid", 64'(bus.avalonst_source_valid), 64'(0));
        drive(1'b0, 1'b0, ADDR_DATA, 32'h0, 1'b1);
        cycle();
        check("t1 e2 valid", 64'(bus.avalonst_source_valid), 64'(0));
        cycle();
        check("t1 e3 valid", 64'(bus.avalonst_source_valid), 64'(1));
        check("t1 e3 data", 64'(bus.avalonst_source_data), 64'(32'hA5A5_A5A5));
        check("t1 e3 sop/eop", 64'({bus.avalonst_source_startofpacket, bus.avalonst_source_endofpacket}), 64'(0));
        check("t1 e3 level", 64'(level), 64'(1));
        cycle();
        check("t1 e4 level", 64'(level), 64'(0));
        check("t1 e4 valid", 64'(bus.avalonst_source_valid), 64'(0));

        // Packet framing through the control register
        seen.delete();
        drive(1'b1, 1'b0, ADDR_CTRL, 32'h1, 1'b1);  cycle();
        drive(1'b1, 1'b0, ADDR_DATA, 32'h10, 1'b1); cycle();
        drive(1'b1, 1'b0, ADDR_DATA, 32'h11, 1'b1); cycle();
        drive(1'b1, 1'b0, ADDR_CTRL, 32'h2, 1'b1);  cycle();
        drive(1'b1, 1'b0, ADDR_DATA, 32'h12, 1'b1); cycle();
        idle(1'b1, 5);
        drive(1'b0, 1'b1, ADDR_CTRL, 32'h0, 1'b1);  cycle();
        check("t2 pending flags", 64'(bus.avalonmm_slave_readdata), 64'(0));
        check("t2 word count", 64'(seen.size()), 64'(3));
        if (seen.size() == 3) begin
            check("t2 w0", 64'({seen[0].sop, seen[0].eop, seen[0].data}), {30'h0, 2'b10, 32'h10});
            check("t2 w1", 64'({seen[1].sop, seen[1].eop, seen[1].data}), {30'h0, 2'b00, 32'h11});
            check("t2 w2", 64'({seen[2].sop, seen[2].eop, seen[2].data}), {30'h0, 2'b01, 32'h12});
        end

        // Full FIFO stalls the ninth write until one word leaves
        seen.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, ADDR_DATA, 32'h200 + 32'(i), 1'b0);
            cycle();
        end
        check("t3 full level", 64'(level), 64'(8));
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, ADDR_DATA, 32'h208, 1'b0);
            cycle();
            check("t3 stall", 64'(wreq_seen), 64'(1));
        end
        drive(1'b1, 1'b0, ADDR_DATA, 32'h208, 1'b1);
        cycle();
        check("t3 stall at pop", 64'(wreq_seen), 64'(1));
        check("t3 level after pop", 64'(level), 64'(7));
        drive(1'b1, 1'b0, ADDR_DATA, 32'h208, 1'b0);
        cycle();
        check("t3 released", 64'(wreq_seen), 64'(0));
        check("t3 level refilled", 64'(level), 64'(8));
        idle(1'b1, DEPTH + 4);
        check("t3 word count", 64'(seen.size()), 64'(9));
        for (int i = 0; i < seen.size(); i++)
            check("t3 order", 64'(seen[i].data), 64'(32'h200 + 32'(i)));

        // Almost-full threshold, table-driven
        vecs[0] = '{1'b1, 1'b0, ADDR_AFTHR, 32'd5,   1'b0, 0, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[1] = '{1'b1, 1'b0, ADDR_DATA,  32'h100, 1'b0, 1, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[2] = '{1'b1, 1'b0, ADDR_DATA,  32'h101, 1'b0, 2, 1'b0, 1'b0, 1'b0, 32'd0};
        vecs[3] = '{1'b1, 1'b0, ADDR_DATA,  32'h102, 1'b0, 3, 1'b0, 1'b1, 1'b0, 32'd0};
        vecs[4] = '{1'b1, 1'b0, ADDR_DATA,  32'h103, 1'b0, 4, 1'b0, 1'b1, 1'b0, 32'd0};
        vecs[5] = '{1'b1, 1'b0, ADDR_DATA,  32'h104, 1'b0, 5, 1'b1, 1'b1, 1'b0, 32'd0};
        vecs[6] = '{1'b0, 1'b0, ADDR_DATA,  32'h0,   1'b1, 4, 1'b0, 1'b1, 1'b0, 32'd0};
        vecs[7] = '{1'b0, 1'b1, ADDR_LEVEL, 32'h0,   1'b0, 4, 1'b0, 1'b1, 1'b1, 32'd4};
        vecs[8] = '{1'b0, 1'b1, ADDR_AFTHR, 32'h0,   1'b0, 4, 1'b0, 1'b1, 1'b1, 32'd5};
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wd, vecs[i].rdy);
            cycle();
            check($sformatf("t4[%0d] level", i), 64'(level), 64'(vecs[i].exp_level));
            check($sformatf("t4[%0d] almost_full", i), 64'(almost_full), 64'(vecs[i].exp_af));
            check($sformatf("t4[%0d] valid", i), 64'(bus.avalonst_source_valid), 64'(vecs[i].exp_valid));
            if (vecs[i].chk_rd)
                check($sformatf("t4[%0d] readdata", i), 64'(bus.avalonmm_slave_readdata), 64'(vecs[i].exp_rd));
        end
        idle(1'b1, DEPTH + 4);

        // Streaming across several pointer wraps; steady state holds three words
        seen.delete();
        started = 1'b0;
        bubbles = 0;
        max_lvl = 0;
        for (int i = 0; i < 3 * int'(DEPTH); i++) begin
            drive(1'b1, 1'b0, ADDR_DATA, 32'h300 + 32'(i), 1'b1);
            cycle();
            if (bus.avalonst_source_valid) started = 1'b1;
            else if (started) bubbles++;
            if (int'(level) > max_lvl) max_lvl = int'(level);
        end
        idle(1'b1, 6);
        check("t5 bubbles", 64'(bubbles), 64'(0));
        check("t5 max level", 64'(max_lvl <= 3), 64'(1));
        check("t5 word count", 64'(seen.size()), 64'(3 * DEPTH));
        for (int i = 0; i < seen.size(); i++)
            check("t5 order", 64'(seen[i].data), 64'(32'h300 + 32'(i)));

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            int op;
            logic rdy;
            op  = int'($urandom_range(0, 10));
            rdy = ($urandom_range(0, 3) != 0);
            case (op)
                0, 1, 2, 3, 4, 5: drive(1'b1, 1'b0, ADDR_DATA, $urandom(), rdy);
                6: drive(1'b1, 1'b0, ADDR_CTRL, 32'($urandom_range(0, 3)), rdy);
                7: drive(1'b1, 1'b0, ADDR_AFTHR, 32'($urandom_range(0, DEPTH)), rdy);
                8: drive(1'b0, 1'b1, 2'($urandom_range(1, 3)), 32'h0, rdy);
                9: drive(1'b1, 1'b0, ADDR_LEVEL, $urandom(), rdy);
                default: drive(1'b0, 1'b0, ADDR_DATA, 32'h0, rdy);
            endcase
            cycle();
        end
        idle(1'b1, DEPTH + 4);

        // Asynchronous reset mid-stream
        drive(1'b1, 1'b0, ADDR_AFTHR, 32'd3, 1'b0); cycle();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, ADDR_DATA, 32'h400 + 32'(i), 1'b0);
            cycle();
        end
        drive(1'b1, 1'b0, ADDR_CTRL, 32'h1, 1'b0); cycle();
        drive(1'b0, 1'b0, ADDR_DATA, 32'h0, 1'b0);
        check("t7 level before reset", 64'(level), 64'(6));
        check("t7 af before reset", 64'(almost_full), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        check("t7 reset valid", 64'(bus.avalonst_source_valid), 64'(0));
        check("t7 reset level", 64'(level), 64'(0));
        check("t7 reset almost_full", 64'(almost_full), 64'(0));
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        seen.delete();
        drive(1'b0, 1'b1, ADDR_AFTHR, 32'h0, 1'b1); cycle();
        check("t7 threshold default", 64'(bus.avalonmm_slave_readdata), 64'(AFD));
        drive(1'b1, 1'b0, ADDR_DATA, 32'h55, 1'b1); cycle();
        idle(1'b1, 4);
        check("t7 word count", 64'(seen.size()), 64'(1));
        if (seen.size() == 1) begin
            check("t7 first word sop", 64'(seen[0].sop), 64'(0));
            check("t7 first word data", 64'(seen[0].data), 64'(32'h55));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
